// File: rtl/bus_dev_fifo.sv
// Bus device with a TX FIFO (device -> bus) and an RX FIFO (bus -> device).
// Define BUS_DEV_RX_ID_FILTER_EN to discard RX packets addressed to other devices.

// Occupancy FSM
// state     | meaning
// S_EMPTY   | no entries, head not valid
// S_PARTIAL | 1..DEPTH-1 entries
// S_FULL    | DEPTH entries, writes only accepted alongside a read
module bus_dev_fifo_q #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_wr,
    input  logic [W-1:0] i_wr_data,
    input  logic         i_rd,
    output logic [W-1:0] o_head,
    output logic         o_not_empty,
    output logic         o_full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_PARTIAL = 2'd1,
        S_FULL    = 2'd2
    } state_t;

    state_t        r_state;
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          w_rd_ok;
    logic          w_wr_ok;

    // A read on a full FIFO frees the slot the simultaneous write lands in.
    assign w_rd_ok = i_rd && (r_state != S_EMPTY);
    assign w_wr_ok = i_wr && ((r_state != S_FULL) || w_rd_ok);

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_ok && !w_rd_ok)
            w_count_nxt = r_count + CW'(1);
        else if (!w_wr_ok && w_rd_ok)
            w_count_nxt = r_count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_EMPTY;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_ok)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd_ok)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
            if (w_wr_ok != w_rd_ok) begin
                if (w_count_nxt == '0)
                    r_state <= S_EMPTY;
                else if (w_count_nxt == CW'(DEPTH))
                    r_state <= S_FULL;
                else
                    r_state <= S_PARTIAL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_wr_ok)
            r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_head      = r_mem[r_rd_ptr];
    assign o_not_empty = (r_state != S_EMPTY);
    assign o_full      = (r_state == S_FULL);
endmodule

module bus_dev_fifo #(
    parameter int pckg_sz = 16,
    parameter int depth   = 8,
    parameter int id      = 0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    input  logic               dev_wr,
    input  logic [pckg_sz-1:0] dev_wr_data,
    output logic               dev_full,
    input  logic               dev_rd,
    output logic [pckg_sz-1:0] dev_rd_data,
    output logic               dev_rx_valid,
    output logic               tx_ovf,
    output logic               rx_ovf,
    output logic [7:0]         rx_drop_cnt
);
    if (pckg_sz < 9 || depth < 2 || depth > 256 || (depth & (depth - 1)) != 0 ||
        id < 0 || id > 255) begin : g_param_check
        $error("bus_dev_fifo: illegal parameter value");
    end

    logic       w_rx_keep;
    logic       w_rx_push;
    logic       w_rx_full;
    logic       w_tx_drop;
    logic       w_rx_ovf_drop;
    logic       w_rx_filt_drop;
    logic       r_tx_ovf;
    logic       r_rx_ovf;
    logic [7:0] r_rx_drop_cnt;

`ifdef BUS_DEV_RX_ID_FILTER_EN
    logic [7:0] w_dest;
    assign w_dest    = D_push[pckg_sz-1 -: 8];
    assign w_rx_keep = (w_dest == 8'(id)) || (w_dest == 8'hFF);
`else
    assign w_rx_keep = 1'b1;
`endif

    assign w_rx_push = push && w_rx_keep;

    bus_dev_fifo_q #(.W(pckg_sz), .DEPTH(depth)) u_tx (
        .clk         (clk),
        .reset       (reset),
        .i_wr        (dev_wr),
        .i_wr_data   (dev_wr_data),
        .i_rd        (pop),
        .o_head      (D_pop),
        .o_not_empty (pndng),
        .o_full      (dev_full)
    );

    bus_dev_fifo_q #(.W(pckg_sz), .DEPTH(depth)) u_rx (
        .clk         (clk),
        .reset       (reset),
        .i_wr        (w_rx_push),
        .i_wr_data   (D_push),
        .i_rd        (dev_rd),
        .o_head      (dev_rd_data),
        .o_not_empty (dev_rx_valid),
        .o_full      (w_rx_full)
    );

    // When full the head is always valid, so any read frees a slot.
    assign w_tx_drop      = dev_wr && dev_full && !pop;
    assign w_rx_ovf_drop  = w_rx_push && w_rx_full && !dev_rd;
    assign w_rx_filt_drop = push && !w_rx_keep;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_ovf      <= 1'b0;
            r_rx_ovf      <= 1'b0;
            r_rx_drop_cnt <= 8'd0;
        end else begin
            if (w_tx_drop)
                r_tx_ovf <= 1'b1;
            if (w_rx_ovf_drop)
                r_rx_ovf <= 1'b1;
            if ((w_rx_ovf_drop || w_rx_filt_drop) && (r_rx_drop_cnt != 8'hFF))
                r_rx_drop_cnt <= r_rx_drop_cnt + 8'd1;
        end
    end

    assign tx_ovf      = r_tx_ovf;
    assign rx_ovf      = r_rx_ovf;
    assign rx_drop_cnt = r_rx_drop_cnt;
endmodule

// File: tb/tb_bus_dev_fifo.sv
// Self-checking bench for bus_dev_fifo: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_bus_dev_fifo;
    localparam int W  = 16;
    localparam int D  = 8;
    localparam int ID = 5;

    logic         clk = 1'b0;
    logic         reset;
    logic         pndng;
    logic [W-1:0] D_pop;
    logic         pop;
    logic         push;
    logic [W-1:0] D_push;
    logic         dev_wr;
    logic [W-1:0] dev_wr_data;
    logic         dev_full;
    logic         dev_rd;
    logic [W-1:0] dev_rd_data;
    logic         dev_rx_valid;
    logic         tx_ovf;
    logic         rx_ovf;
    logic [7:0]   rx_drop_cnt;

    always #5 clk = ~clk;

    bus_dev_fifo #(.pckg_sz(W), .depth(D), .id(ID)) dut (
        .clk          (clk),
        .reset        (reset),
        .pndng        (pndng),
        .D_pop        (D_pop),
        .pop          (pop),
        .push         (push),
        .D_push       (D_push),
        .dev_wr       (dev_wr),
        .dev_wr_data  (dev_wr_data),
        .dev_full     (dev_full),
        .dev_rd       (dev_rd),
        .dev_rd_data  (dev_rd_data),
        .dev_rx_valid (dev_rx_valid),
        .tx_ovf       (tx_ovf),
        .rx_ovf       (rx_ovf),
        .rx_drop_cnt  (rx_drop_cnt)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [W-1:0] m_tx[$];
    logic [W-1:0] m_rx[$];
    bit           m_tx_ovf;
    bit           m_rx_ovf;
    int           m_drop;

    typedef struct {
        logic         rst;
        logic         wr;
        logic [W-1:0] wd;
        logic         pp;
        logic         ps;
        logic [W-1:0] pd;
        logic         rd;
        logic         e_pndng;
        logic [W-1:0] e_dpop;
        logic         e_rxv;
        logic [W-1:0] e_rdd;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    task automatic model_drop();
        if (m_drop < 255)
            m_drop++;
    endtask

    task automatic model_step(input logic rst, input logic wr, input logic [W-1:0] wd,
                              input logic pp, input logic ps, input logic [W-1:0] pd,
                              input logic rd);
        bit tx_rd;
        bit tx_wr;
        bit rx_rd;
        bit keep;
        if (rst) begin
            m_tx.delete();
            m_rx.delete();
            m_tx_ovf = 1'b0;
            m_rx_ovf = 1'b0;
            m_drop   = 0;
        end else begin
            tx_rd = pp && (m_tx.size() > 0);
            tx_wr = wr && ((m_tx.size() < D) || tx_rd);
            if (wr && !tx_wr)
                m_tx_ovf = 1'b1;
            if (tx_rd)
                void'(m_tx.pop_front());
            if (tx_wr)
                m_tx.push_back(wd);

            keep = 1'b1;
`ifdef BUS_DEV_RX_ID_FILTER_EN
            keep = (pd[W-1 -: 8] == 8'(ID)) || (pd[W-1 -: 8] == 8'hFF);
`endif
            rx_rd = rd && (m_rx.size() > 0);
            if (rx_rd)
                void'(m_rx.pop_front());
            if (ps && !keep) begin
                model_drop();
            end else if (ps) begin
                if (m_rx.size() < D) begin
                    m_rx.push_back(pd);
                end else begin
                    m_rx_ovf = 1'b1;
                    model_drop();
                end
            end
        end
    endtask

    task automatic compare_model();
        chk("pndng", pndng, m_tx.size() > 0);
        chk("dev_full", dev_full, m_tx.size() == D);
        chk("dev_rx_valid", dev_rx_valid, m_rx.size() > 0);
        chk("tx_ovf", tx_ovf, m_tx_ovf);
        chk("rx_ovf", rx_ovf, m_rx_ovf);
        chk("rx_drop_cnt", rx_drop_cnt, m_drop);
        if (m_tx.size() > 0)
            chk("D_pop", D_pop, m_tx[0]);
        if (m_rx.size() > 0)
            chk("dev_rd_data", dev_rd_data, m_rx[0]);
    endtask

    task automatic cyc(input logic rst, input logic wr, input logic [W-1:0] wd,
                       input logic pp, input logic ps, input logic [W-1:0] pd,
                       input logic rd);
        reset       = rst;
        dev_wr      = wr;
        dev_wr_data = wd;
        pop         = pp;
        push        = ps;
        D_push      = pd;
        dev_rd      = rd;
        @(posedge clk);
        model_step(rst, wr, wd, pp, ps, pd, rd);
        #1;
        compare_model();
    endtask

    task automatic idle_rst();
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        logic [W-1:0] exp_rx[$];

        vt[0]  = '{1'b0, 1'b1, 16'h0101, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0101, 1'b0, 16'h0000};
        vt[1]  = '{1'b0, 1'b1, 16'h0202, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0101, 1'b0, 16'h0000};
        vt[2]  = '{1'b0, 1'b1, 16'h0303, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0101, 1'b0, 16'h0000};
        vt[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0202, 1'b0, 16'h0000};
        vt[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0303, 1'b0, 16'h0000};
        vt[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vt[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0512, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0512};
        vt[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hFF78, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hFF78};
        vt[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vt[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vt[10] = '{1'b0, 1'b1, 16'hAAAA, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hAAAA, 1'b0, 16'h0000};
        vt[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hFF22, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hFF22};

        reset = 1'b1; dev_wr = 1'b0; dev_wr_data = '0; pop = 1'b0;
        push = 1'b0; D_push = '0; dev_rd = 1'b0;

        // Reset state
        idle_rst();
        idle_rst();
        chk("rst pndng", pndng, 1'b0);
        chk("rst dev_full", dev_full, 1'b0);
        chk("rst dev_rx_valid", dev_rx_valid, 1'b0);
        chk("rst tx_ovf", tx_ovf, 1'b0);
        chk("rst rx_ovf", rx_ovf, 1'b0);
        chk("rst rx_drop_cnt", rx_drop_cnt, 8'd0);

        foreach (vt[i]) begin
            cyc(vt[i].rst, vt[i].wr, vt[i].wd, vt[i].pp, vt[i].ps, vt[i].pd, vt[i].rd);
            chk($sformatf("vec%0d pndng", i), pndng, vt[i].e_pndng);
            if (vt[i].e_pndng)
                chk($sformatf("vec%0d D_pop", i), D_pop, vt[i].e_dpop);
            chk($sformatf("vec%0d dev_rx_valid", i), dev_rx_valid, vt[i].e_rxv);
            if (vt[i].e_rxv)
                chk($sformatf("vec%0d dev_rd_data", i), dev_rd_data, vt[i].e_rdd);
        end

        // TX overflow: ninth write dropped, first eight drain in order
        idle_rst();
        for (int i = 0; i < 9; i++) begin
            cyc(1'b0, 1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0, '0, 1'b0);
            if (i == 7) begin
                chk("tx8 dev_full", dev_full, 1'b1);
                chk("tx8 tx_ovf", tx_ovf, 1'b0);
            end
        end
        chk("tx9 tx_ovf", tx_ovf, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk("tx drain D_pop", D_pop, 16'h1000 + 16'(i));
            cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        end
        chk("tx drained pndng", pndng, 1'b0);

        // TX full with simultaneous write and pop
        idle_rst();
        for (int i = 0; i < 8; i++)
            cyc(1'b0, 1'b1, 16'h2000 + 16'(i), 1'b0, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b1, 16'h0BEE, 1'b1, 1'b0, '0, 1'b0);
        chk("txwp dev_full", dev_full, 1'b1);
        chk("txwp tx_ovf", tx_ovf, 1'b0);
        for (int i = 1; i < 9; i++) begin
            chk("txwp order", D_pop, (i == 8) ? 16'h0BEE : 16'h2000 + 16'(i));
            cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        end

        // RX overflow, then push with dev_rd on full RX
        idle_rst();
        for (int i = 0; i < 8; i++)
            cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 16'hFF00 + 16'(i), 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 16'h05AA, 1'b0);
        chk("rxovf rx_ovf", rx_ovf, 1'b1);
        chk("rxovf drop", rx_drop_cnt, 8'd1);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 16'h05BB, 1'b1);
        chk("rxpr drop", rx_drop_cnt, 8'd1);
        for (int i = 1; i < 9; i++) begin
            chk("rxpr order", dev_rd_data, (i == 8) ? 16'h05BB : 16'hFF00 + 16'(i));
            cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        end
        chk("rxpr empty", dev_rx_valid, 1'b0);

        // Drop counter saturates at 255
        idle_rst();
        for (int i = 0; i < 8 + 300; i++)
            cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 16'hFF00 + 16'(i), 1'b0);
        chk("drop saturate", rx_drop_cnt, 8'd255);

        // Destination filter behaviour (id = 5)
        idle_rst();
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 16'h05AA, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 16'hFF11, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 16'h0733, 1'b0);
`ifdef BUS_DEV_RX_ID_FILTER_EN
        exp_rx = '{16'h05AA, 16'hFF11};
        chk("filter drop", rx_drop_cnt, 8'd1);
`else
        exp_rx = '{16'h05AA, 16'hFF11, 16'h0733};
        chk("nofilter drop", rx_drop_cnt, 8'd0);
`endif
        chk("filter rx_ovf", rx_ovf, 1'b0);
        foreach (exp_rx[i]) begin
            chk("filter rx data", dev_rd_data, exp_rx[i]);
            cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        end
        chk("filter rx empty", dev_rx_valid, 1'b0);

        // Reset with traffic in flight
        idle_rst();
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 1'b1, 16'h3000 + 16'(i), 1'b0, 1'b1, 16'hFF30 + 16'(i), 1'b0);
        for (int i = 0; i < 9; i++)
            cyc(1'b0, 1'b1, 16'h3100 + 16'(i), 1'b0, 1'b1, 16'hFF40 + 16'(i), 1'b0);
        chk("pre-rst tx_ovf", tx_ovf, 1'b1);
        cyc(1'b1, 1'b1, 16'h4444, 1'b1, 1'b1, 16'hFF44, 1'b1);
        chk("inrst pndng", pndng, 1'b0);
        chk("inrst dev_rx_valid", dev_rx_valid, 1'b0);
        chk("inrst dev_full", dev_full, 1'b0);
        chk("inrst tx_ovf", tx_ovf, 1'b0);
        chk("inrst rx_ovf", rx_ovf, 1'b0);
        chk("inrst drop", rx_drop_cnt, 8'd0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);

        // Randomized traffic, phases alternate bias to visit full and empty
        for (int ph = 0; ph < 8; ph++) begin
            int pw;
            int pr;
            pw = (ph % 2 == 0) ? 75 : 25;
            pr = 100 - pw;
            for (int c = 0; c < 400; c++) begin
                logic [W-1:0] pd;
                logic [7:0]   dst;
                case ($urandom_range(0, 2))
                    0:       dst = 8'(ID);
                    1:       dst = 8'hFF;
                    default: dst = 8'($urandom);
                endcase
                pd = {dst, 8'($urandom)};
                cyc($urandom_range(0, 299) == 0,
                    $urandom_range(0, 99) < pw, 16'($urandom),
                    $urandom_range(0, 99) < pr,
                    $urandom_range(0, 99) < pw, pd,
                    $urandom_range(0, 99) < pr);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
